// File: rtl/mv_block_fetch.sv
// mv_block_fetch: turns one decoded half-pel motion vector into
// per-row frame-memory read requests for one reference block.
module mv_block_fetch #(
  parameter int WIDTH  = 352,
  parameter int HEIGHT = 288,
  parameter int ADDR_W = 20,
  parameter int BLK    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        mb_x,
  input  logic [5:0]        mb_y,
  input  logic [31:0]       mv_x,
  input  logic [31:0]       mv_y,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [4:0]        req_len,
  output logic              req_last,
  output logic              out_hx,
  output logic              out_hy,
  output logic              out_clip,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [5:0]         mbx_q, mbx_d;
  logic [5:0]         mby_q, mby_d;
  logic signed [31:0] mvx_q, mvx_d;
  logic signed [31:0] mvy_q, mvy_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [4:0]         len_q, len_d;
  logic [4:0]         row_q, row_d;
  logic [4:0]         nrows_q, nrows_d;
  logic               last_q, last_d;
  logic               hx_q, hx_d;
  logic               hy_q, hy_d;
  logic               clip_q, clip_d;

  logic signed [31:0] x_raw, y_raw;
  logic signed [31:0] x_max, y_max;
  logic signed [31:0] x_cl, y_cl;
  logic [ADDR_W-1:0]  base;
  logic               hx_c, hy_c;
  logic               x_clip, y_clip;
  logic [4:0]         nrows_c;

  // Reference position from captured inputs; only consumed in S_CALC.
  always_comb begin
    hx_c  = mvx_q[0];
    hy_c  = mvy_q[0];
    x_raw = $signed(32'(mbx_q) * 32'(BLK)) + (mvx_q >>> 1);
    y_raw = $signed(32'(mby_q) * 32'(BLK)) + (mvy_q >>> 1);
    x_max = WIDTH - BLK - int'(hx_c);
    y_max = HEIGHT - BLK - int'(hy_c);
    x_cl   = x_raw;
    x_clip = 1'b0;
    if (x_raw < 0) begin
      x_cl   = 0;
      x_clip = 1'b1;
    end else if (x_raw > x_max) begin
      x_cl   = x_max;
      x_clip = 1'b1;
    end
    y_cl   = y_raw;
    y_clip = 1'b0;
    if (y_raw < 0) begin
      y_cl   = 0;
      y_clip = 1'b1;
    end else if (y_raw > y_max) begin
      y_cl   = y_max;
      y_clip = 1'b1;
    end
    base    = ADDR_W'(y_cl * WIDTH + x_cl);
    nrows_c = 5'(BLK + int'(hy_c));
  end

  always_comb begin
    state_d = state_q;
    mbx_d   = mbx_q;
    mby_d   = mby_q;
    mvx_d   = mvx_q;
    mvy_d   = mvy_q;
    addr_d  = addr_q;
    len_d   = len_q;
    row_d   = row_q;
    nrows_d = nrows_q;
    last_d  = last_q;
    hx_d    = hx_q;
    hy_d    = hy_q;
    clip_d  = clip_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mbx_d   = mb_x;
          mby_d   = mb_y;
          mvx_d   = mv_x;
          mvy_d   = mv_y;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        hx_d    = hx_c;
        hy_d    = hy_c;
        clip_d  = x_clip | y_clip;
        addr_d  = base;
        len_d   = 5'(BLK + int'(hx_c));
        nrows_d = nrows_c;
        row_d   = 5'd0;
        last_d  = (nrows_c == 5'd1);
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (req_ready) begin
          if (last_q) begin
            addr_d  = '0;
            len_d   = 5'd0;
            last_d  = 1'b0;
            row_d   = 5'd0;
            state_d = S_DONE;
          end else begin
            row_d  = row_q + 5'd1;
            addr_d = addr_q + ADDR_W'(WIDTH);
            last_d = (row_q + 5'd1) == (nrows_q - 5'd1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mbx_q   <= '0;
      mby_q   <= '0;
      mvx_q   <= '0;
      mvy_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      row_q   <= '0;
      nrows_q <= '0;
      last_q  <= 1'b0;
      hx_q    <= 1'b0;
      hy_q    <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mbx_q   <= mbx_d;
      mby_q   <= mby_d;
      mvx_q   <= mvx_d;
      mvy_q   <= mvy_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      row_q   <= row_d;
      nrows_q <= nrows_d;
      last_q  <= last_d;
      hx_q    <= hx_d;
      hy_q    <= hy_d;
      clip_q  <= clip_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign req_valid = (state_q == S_ISSUE);
  assign done      = (state_q == S_DONE);
  assign req_addr  = addr_q;
  assign req_len   = len_q;
  assign req_last  = last_q;
  assign out_hx    = hx_q;
  assign out_hy    = hy_q;
  assign out_clip  = clip_q;

endmodule

// File: tb/tb_mv_block_fetch.sv
// tb_mv_block_fetch: random and directed blocks checked against
// a queue of expected row requests built from the block geometry.
module tb_mv_block_fetch;
  localparam int W = 352;
  localparam int H = 288;
  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  mb_x = '0;
  logic [5:0]  mb_y = '0;
  logic [31:0] mv_x = '0;
  logic [31:0] mv_y = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [19:0] req_addr;
  logic [4:0]  req_len;
  logic        req_last;
  logic        out_hx, out_hy, out_clip, done;

  typedef struct {
    int addr;
    int len;
    bit last;
  } req_t;

  req_t exp_q[$];
  int   exp_hx, exp_hy, exp_clip;
  int   checks = 0;
  int   errors = 0;
  int   rows_done = 0;
  int   done_cnt = 0;
  bit   pending_done = 0;
  bit   lst;
  int   ready_pct = 100;
  int   stall_cnt = 0;

  always #5 clk = ~clk;

  mv_block_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mb_x(mb_x), .mb_y(mb_y),
    .mv_x(mv_x), .mv_y(mv_y),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .req_last(req_last),
    .out_hx(out_hx), .out_hy(out_hy),
    .out_clip(out_clip), .done(done)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Geometry straight from the block definition: clamp, then one
  // entry per reference row, stride W, 20-bit address wrap.
  function automatic void model(input int mbx, input int mby,
                                input int mvx, input int mvy);
    int hx, hy, x, y, xm, ym, base, n;
    bit clip;
    req_t t;
    hx = mvx & 1;
    hy = mvy & 1;
    x  = mbx * B + (mvx >>> 1);
    y  = mby * B + (mvy >>> 1);
    xm = W - B - hx;
    ym = H - B - hy;
    clip = 0;
    if (x < 0) begin x = 0; clip = 1; end
    else if (x > xm) begin x = xm; clip = 1; end
    if (y < 0) begin y = 0; clip = 1; end
    else if (y > ym) begin y = ym; clip = 1; end
    base = y * W + x;
    n = B + hy;
    for (int r = 0; r < n; r++) begin
      t.addr = (base + r * W) & 32'hFFFFF;
      t.len  = B + hx;
      t.last = (r == n - 1);
      exp_q.push_back(t);
    end
    exp_hx   = hx;
    exp_hy   = hy;
    exp_clip = clip;
  endfunction

  always @(posedge clk) begin
    #1;
    if (stall_cnt > 0) begin
      req_ready = 1'b0;
      stall_cnt--;
    end else begin
      req_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (pending_done) begin
        chk("done_pulse", done, 1);
        chk("valid_drop", req_valid, 0);
        chk("out_hx", out_hx, exp_hx);
        chk("out_hy", out_hy, exp_hy);
        chk("out_clip", out_clip, exp_clip);
        pending_done = 0;
        done_cnt++;
      end else if (done !== 1'b0) begin
        chk("unexpected_done", done, 0);
      end
      if (req_valid === 1'b1) begin
        chk("busy_in_ready", in_ready, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_req", req_valid, 0);
        end else begin
          chk("req_addr", req_addr, exp_q[0].addr);
          chk("req_len", req_len, exp_q[0].len);
          chk("req_last", req_last, exp_q[0].last);
          if (req_ready) begin
            lst = exp_q[0].last;
            void'(exp_q.pop_front());
            rows_done++;
            if (lst) pending_done = 1;
          end
        end
      end
    end
  end

  task automatic run_block(input int mbx, input int mby,
                           input int mvx, input int mvy,
                           input bit hold);
    int n, d0;
    @(posedge clk); #1;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_idle", in_ready, 1);
    mb_x = 6'(mbx);
    mb_y = 6'(mby);
    mv_x = mvx;
    mv_y = mvy;
    in_valid = 1'b1;
    model(mbx, mby, mvx, mvy);
    rows_done = 0;
    d0 = done_cnt;
    @(posedge clk); #1;
    if (hold) begin
      mb_x = 6'($urandom);
      mb_y = 6'($urandom);
      mv_x = $urandom;
      mv_y = $urandom;
    end else begin
      in_valid = 1'b0;
    end
    @(negedge clk);
    chk("lat_calc", req_valid, 0);
    @(negedge clk);
    chk("lat_issue", req_valid, 1);
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("done_seen", done_cnt - d0, 1);
    @(negedge clk);
    chk("hold_hx", out_hx, exp_hx);
    chk("hold_clip", out_clip, exp_clip);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, d0;
    model(0, 0, 0, 0);
    chk("m1_rows", exp_q.size(), 16);
    chk("m1_addr15", exp_q[15].addr, 5280);
    chk("m1_last", exp_q[15].last, 1);
    exp_q.delete();
    model(1, 1, 3, -2);
    chk("m2_addr0", exp_q[0].addr, 5297);
    chk("m2_len", exp_q[0].len, 17);
    chk("m2_rows", exp_q.size(), 16);
    chk("m2_hx", exp_hx, 1);
    exp_q.delete();
    model(0, 0, -40, 1);
    chk("m3_rows", exp_q.size(), 17);
    chk("m3_addr16", exp_q[16].addr, 5632);
    chk("m3_clip", exp_clip, 1);
    exp_q.delete();

    #1 rst = 1'b0;
    #1;
    chk("rst_valid", req_valid, 0);
    chk("rst_addr", req_addr, 0);
    chk("rst_len", req_len, 0);
    chk("rst_last", req_last, 0);
    chk("rst_hx", out_hx, 0);
    chk("rst_hy", out_hy, 0);
    chk("rst_clip", out_clip, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 1);
    #20;
    @(negedge clk) rst = 1'b1;

    run_block(0, 0, 0, 0, 0);
    run_block(1, 1, 3, -2, 0);
    run_block(0, 0, -40, 1, 0);

    rows_done = 0;
    fork
      run_block(0, 0, 0, 0, 0);
      begin
        n = 0;
        while (rows_done < 5 && n < 300) begin
          @(negedge clk); #1;
          n++;
        end
        stall_cnt = 3;
        repeat (3) begin
          @(negedge clk);
          chk("stall_addr", req_addr, 5 * W);
          chk("stall_valid", req_valid, 1);
        end
      end
    join

    @(posedge clk); #1;
    in_valid = 1'b1;
    mb_x = 6'd2; mb_y = 6'd3; mv_x = 5; mv_y = 7;
    model(2, 3, 5, 7);
    rows_done = 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (rows_done < 7 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("row7_reach", rows_done, 7);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("mid_valid", req_valid, 0);
    chk("mid_addr", req_addr, 0);
    chk("mid_len", req_len, 0);
    chk("mid_last", req_last, 0);
    chk("mid_hx", out_hx, 0);
    chk("mid_hy", out_hy, 0);
    chk("mid_done", done, 0);
    exp_q.delete();
    pending_done = 0;
    d0 = done_cnt;
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_done_after_rst", done_cnt, d0);
    run_block(0, 0, 0, 0, 0);

    run_block(4, 2, -1, -1, 1);
    repeat (3) @(negedge clk);
    chk("hold_no_extra", exp_q.size(), 0);

    repeat (40) begin
      int mvx, mvy;
      ready_pct = $urandom_range(30, 100);
      mvx = int'($urandom_range(0, 1400)) - 700;
      mvy = int'($urandom_range(0, 1400)) - 700;
      if ($urandom_range(0, 9) == 0) mvx = -1;
      if ($urandom_range(0, 9) == 0) mvy = -1;
      run_block($urandom_range(0, 25), $urandom_range(0, 20),
                mvx, mvy, 1'($urandom_range(0, 1)));
    end

    ready_pct = 100;
    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
